axi_sys_slave: RTL and testbench
================================

# axi_sys_slave

AXI3 slave endpoint that terminates single-beat AXI read and write transactions and converts them into strobe/ack accesses on the internal system register bus. It sits between the PS GP AXI port (or a simulation AXI master) and the PL register decoder. It is the responder counterpart of the simulation AXI master tasks. Bursts are not performed on the system bus. They are consumed protocol-correctly and answered with SLVERR.

## Interface
- AW, 32: AXI and system-bus address width
- DW, 32: data width; wstrb/sys_sel width DW/8
- IW, 4: AXI ID width
- LW, 4: AXI burst-length width
- TO, 255: system-bus ack timeout in cycles (≥1)

Ports:
- aclk_i  in  1  clock; all logic on rising edge
- arst_i  in  1  reset, synchronous, active-high
- awid_i/awaddr_i/awlen_i/awsize_i/awburst_i/awprot_i/awcache_i/awlock_i  in  IW/AW/LW/3/2/3/4/2  write address; only id, addr, len used
- awvalid_i in 1, awready_o out 1: AW handshake
- wdata_i in DW, wstrb_i in DW/8, wlast_i in 1, wvalid_i in 1, wready_o out 1: W channel
- bid_o out IW, bresp_o out 2, bvalid_o out 1, bready_i in 1: B channel
- arid_i/araddr_i/arlen_i/arsize_i/arburst_i/arprot_i/arcache_i/arlock_i  in  as AW  read address; only id, addr, len used
- arvalid_i in 1, arready_o out 1: AR handshake
- rid_o out IW, rdata_o out DW, rresp_o out 2, rlast_o out 1, rvalid_o out 1, rready_i in 1: R channel
- sys_addr_o out AW, sys_wdata_o out DW, sys_sel_o out DW/8: system-bus request
- sys_wen_o out 1, sys_ren_o out 1: one-cycle access strobes
- sys_rdata_i in DW, sys_err_i in 1, sys_ack_i in 1: system-bus completion

## Operation
- FSM states: IDLE, WR_DATA, WR_BUS, WR_RESP, RD_BUS, RD_RESP. One transaction is in flight at a time.
- IDLE arbitration:
  - awready_o = IDLE & awvalid_i & grant_w.
  - arready_o = IDLE & arvalid_i & ~grant_w.
  - grant_w = awvalid_i & (~arvalid_i | last_was_rd).
  - last_was_rd resets to 1, so a write wins the first collision. Grants alternate while both channels stay pending.
- AW handshake: latch id, addr, len; go to WR_DATA.
- WR_DATA: wready_o = 1. Each wvalid_i beat is accepted.
  - len=0: capture wdata/wstrb, go to WR_BUS.
  - len≠0: discard beats until the beat with wlast_i, then go to WR_RESP with SLVERR. No bus access.
  - If wlast_i is missing on the len=0 beat, the beat is still accepted (len is authoritative).
- WR_BUS: sys_wen_o pulses for exactly one cycle on entry, with sys_addr_o/sys_wdata_o/sys_sel_o=wstrb held stable until completion.
  - On sys_ack_i: resp = sys_err_i ? SLVERR : OKAY.
  - On timeout: resp = SLVERR.
  - Then go to WR_RESP.
- WR_RESP: bvalid_o=1, bid_o=latched id, bresp_o=resp, held until bready_i. Then go to IDLE.
- AR handshake: latch id, addr, len.
  - len=0: go to RD_BUS.
  - len≠0: go to RD_RESP in error mode.
- RD_BUS: sys_ren_o pulses one cycle. On ack, capture sys_rdata_i and resp = sys_err_i ? SLVERR : OKAY. On timeout, rdata=0 and resp=SLVERR.
- RD_RESP: rvalid_o=1, rid_o=id; rdata_o, rresp_o, rlast_o held until rready_i.
  - Normal mode: single beat, rlast_o=1.
  - Error mode: len+1 beats, rdata_o=0, SLVERR, rlast_o only on beat index len. The beat counter is LW wide.
  - Go to IDLE after the last beat handshake.
- sys_ack_i is ignored outside WR_BUS/RD_BUS. sys_ack_i is honoured in the strobe cycle itself.

## Timing
- Reset (arst_i high at an edge):
  - state=IDLE, last_was_rd=1, timeout counter=0.
  - All valid/ready/strobe outputs 0; all data/id/resp/addr outputs 0.
  - Any in-flight transaction is dropped silently; no B/R response is issued.
- Minimum latency, write, zero-wait slave:
  - AW handshake at cycle 0, W accepted at cycle 1, sys_wen_o and ack at cycle 2, bvalid_o from cycle 3.
- Minimum latency, read: AR at cycle 0, sys_ren_o and ack at cycle 1, rvalid_o from cycle 2.
- Timeout: the counter starts at the strobe cycle. With no ack after TO cycles, the transaction completes with SLVERR on the following edge.
  - An ack arriving in the same cycle as expiry wins (OKAY, or SLVERR if sys_err_i).
- W beats arriving before AW are not accepted (wready_o=0 outside WR_DATA).
- bvalid_o/rvalid_o never drop without a handshake. Payload is stable while valid and not ready.

## Structure
- Package axi_sys_pkg: state enum, RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
- Sub-module axi_sys_timeout: loadable down-counter with start/clear/expired, parameter TO.
- All FSM and channel registers live in axi_sys_slave.

## Test plan
- Write 0x40000010 = 0xDEADBEEF, len 0, id 3, ack 2 cycles later: one sys_wen_o pulse, sys_sel_o=4'hF, bid 3, bresp 0.
- Read 0x40000014, slave returns 0x12345678 with sys_err_i=1: one sys_ren_o pulse, rdata_o 0x12345678, rresp 2'b10, rid as issued, rlast 1.
- Read with no ack and TO=8: rvalid after 9 cycles past the strobe, rresp SLVERR, rdata 0.
- Write burst awlen=3, four W beats: no sys_wen_o, bresp SLVERR. Read arlen=2: three SLVERR beats, rlast only on the third.
- awvalid and arvalid asserted in the same cycle, twice back-to-back: order is write, read, write, read.
- arst_i asserted during WR_BUS: all outputs 0 next cycle, no bvalid. A fresh read afterwards completes normally.

Source files
------------

// File: rtl/axi_sys_pkg.sv
// Shared FSM encoding and AXI response codes for the AXI-to-system-bus slave.
package axi_sys_pkg;
  typedef enum logic [2:0] {IDLE, WR_DATA, WR_BUS, WR_RESP, RD_BUS, RD_RESP} state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic [1:0] bus_resp(input logic err);
    return err ? RESP_SLVERR : RESP_OKAY;
  endfunction
endpackage

// File: rtl/axi_sys_timeout.sv
// Ack watchdog: loaded with TO on the strobe, counts down, flags expiry at zero.
module axi_sys_timeout #(
  parameter int TO = 255
) (
  input  logic aclk_i,
  input  logic arst_i,
  input  logic start,
  input  logic clear,
  output logic expired
);
  localparam int CW = $clog2(TO + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge aclk_i) begin
    if (arst_i || clear) cnt <= '0;
    else if (start)      cnt <= CW'(TO);
    else if (cnt != '0)  cnt <= cnt - 1'b1;
  end

  // Only meaningful while a bus access is outstanding; the FSM ignores it elsewhere.
  assign expired = (cnt == '0);
endmodule

// File: rtl/axi_sys_slave.sv
// AXI3 single-beat slave bridging to the strobe/ack system register bus.
// Bursts are drained protocol-correctly and answered with SLVERR.
module axi_sys_slave
  import axi_sys_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int IW = 4,
  parameter int LW = 4,
  parameter int TO = 255
) (
  input  logic            aclk_i,
  input  logic            arst_i,
  input  logic [IW-1:0]   awid_i,
  input  logic [AW-1:0]   awaddr_i,
  input  logic [LW-1:0]   awlen_i,
  input  logic [2:0]      awsize_i,
  input  logic [1:0]      awburst_i,
  input  logic [2:0]      awprot_i,
  input  logic [3:0]      awcache_i,
  input  logic [1:0]      awlock_i,
  input  logic            awvalid_i,
  output logic            awready_o,
  input  logic [DW-1:0]   wdata_i,
  input  logic [DW/8-1:0] wstrb_i,
  input  logic            wlast_i,
  input  logic            wvalid_i,
  output logic            wready_o,
  output logic [IW-1:0]   bid_o,
  output logic [1:0]      bresp_o,
  output logic            bvalid_o,
  input  logic            bready_i,
  input  logic [IW-1:0]   arid_i,
  input  logic [AW-1:0]   araddr_i,
  input  logic [LW-1:0]   arlen_i,
  input  logic [2:0]      arsize_i,
  input  logic [1:0]      arburst_i,
  input  logic [2:0]      arprot_i,
  input  logic [3:0]      arcache_i,
  input  logic [1:0]      arlock_i,
  input  logic            arvalid_i,
  output logic            arready_o,
  output logic [IW-1:0]   rid_o,
  output logic [DW-1:0]   rdata_o,
  output logic [1:0]      rresp_o,
  output logic            rlast_o,
  output logic            rvalid_o,
  input  logic            rready_i,
  output logic [AW-1:0]   sys_addr_o,
  output logic [DW-1:0]   sys_wdata_o,
  output logic [DW/8-1:0] sys_sel_o,
  output logic            sys_wen_o,
  output logic            sys_ren_o,
  input  logic [DW-1:0]   sys_rdata_i,
  input  logic            sys_err_i,
  input  logic            sys_ack_i
);
  state_t          state_q, state_d;
  logic            last_was_rd_q, grant_w;
  logic [IW-1:0]   id_q;
  logic [AW-1:0]   addr_q;
  logic [LW-1:0]   len_q, beat_q;
  logic [DW-1:0]   wdata_q, rdata_q;
  logic [DW/8-1:0] sel_q;
  logic [1:0]      resp_q;
  logic            tmr_start, tmr_clear, tmr_expired;

  // Attribute fields are accepted for protocol completeness but have no effect here.
  logic unused_attr;
  assign unused_attr = ^{awsize_i, awburst_i, awprot_i, awcache_i, awlock_i,
                         arsize_i, arburst_i, arprot_i, arcache_i, arlock_i};

  axi_sys_timeout #(.TO(TO)) u_tmo (
    .aclk_i  (aclk_i),
    .arst_i  (arst_i),
    .start   (tmr_start),
    .clear   (tmr_clear),
    .expired (tmr_expired)
  );

  always_ff @(posedge aclk_i) begin
    if (arst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    awready_o = 1'b0;
    arready_o = 1'b0;
    wready_o  = 1'b0;
    tmr_start = 1'b0;
    tmr_clear = 1'b0;
    grant_w   = awvalid_i & (~arvalid_i | last_was_rd_q);
    case (state_q)
      IDLE: begin
        awready_o = awvalid_i & grant_w;
        arready_o = arvalid_i & ~grant_w;
        if (awready_o) begin
          state_d = WR_DATA;
        end else if (arready_o) begin
          state_d   = (arlen_i == '0) ? RD_BUS : RD_RESP;
          tmr_start = (arlen_i == '0);
        end
      end
      WR_DATA: begin
        wready_o = 1'b1;
        // The latched length decides, so a len=0 beat without wlast is still taken.
        if (wvalid_i) begin
          if (len_q == '0) begin
            state_d   = WR_BUS;
            tmr_start = 1'b1;
          end else if (wlast_i) begin
            state_d = WR_RESP;
          end
        end
      end
      WR_BUS: if (sys_ack_i || tmr_expired) begin
        state_d   = WR_RESP;
        tmr_clear = 1'b1;
      end
      WR_RESP: if (bready_i) state_d = IDLE;
      RD_BUS: if (sys_ack_i || tmr_expired) begin
        state_d   = RD_RESP;
        tmr_clear = 1'b1;
      end
      RD_RESP: if (rready_i && beat_q == len_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk_i) begin
    if (arst_i) begin
      last_was_rd_q <= 1'b1;
      id_q          <= '0;
      addr_q        <= '0;
      len_q         <= '0;
      beat_q        <= '0;
      wdata_q       <= '0;
      sel_q         <= '0;
      rdata_q       <= '0;
      resp_q        <= RESP_OKAY;
      sys_wen_o     <= 1'b0;
      sys_ren_o     <= 1'b0;
    end else begin
      sys_wen_o <= 1'b0;
      sys_ren_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (awready_o) begin
            id_q          <= awid_i;
            addr_q        <= awaddr_i;
            len_q         <= awlen_i;
            last_was_rd_q <= 1'b0;
          end else if (arready_o) begin
            id_q          <= arid_i;
            addr_q        <= araddr_i;
            len_q         <= arlen_i;
            last_was_rd_q <= 1'b1;
            beat_q        <= '0;
            rdata_q       <= '0;
            resp_q        <= RESP_SLVERR;
            sys_ren_o     <= (arlen_i == '0);
          end
        end
        WR_DATA: if (wvalid_i) begin
          if (len_q == '0) begin
            wdata_q   <= wdata_i;
            sel_q     <= wstrb_i;
            sys_wen_o <= 1'b1;
          end else begin
            resp_q <= RESP_SLVERR;
          end
        end
        // Ack in the expiry cycle takes precedence over the timeout.
        WR_BUS: begin
          if (sys_ack_i)        resp_q <= bus_resp(sys_err_i);
          else if (tmr_expired) resp_q <= RESP_SLVERR;
        end
        RD_BUS: begin
          if (sys_ack_i) begin
            resp_q  <= bus_resp(sys_err_i);
            rdata_q <= sys_rdata_i;
          end else if (tmr_expired) begin
            resp_q  <= RESP_SLVERR;
            rdata_q <= '0;
          end
        end
        RD_RESP: if (rready_i) beat_q <= beat_q + 1'b1;
        default: ;
      endcase
    end
  end

  assign bvalid_o    = (state_q == WR_RESP);
  assign rvalid_o    = (state_q == RD_RESP);
  assign bid_o       = id_q;
  assign rid_o       = id_q;
  assign bresp_o     = resp_q;
  assign rresp_o     = resp_q;
  assign rdata_o     = rdata_q;
  assign rlast_o     = rvalid_o && (beat_q == len_q);
  assign sys_addr_o  = addr_q;
  assign sys_wdata_o = wdata_q;
  assign sys_sel_o   = sel_q;
endmodule

// File: tb/tb_axi_sys_slave.sv
// Scoreboard bench for axi_sys_slave: channel drivers, a modelled system-bus slave
// and a response monitor comparing B/R beats against queued expectations.
module tb_axi_sys_slave;
  localparam int AW = 32, DW = 32, IW = 4, LW = 4, TO = 8;
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

  logic aclk_i = 1'b0, arst_i = 1'b1;
  logic [IW-1:0] awid_i, arid_i, bid_o, rid_o;
  logic [AW-1:0] awaddr_i, araddr_i, sys_addr_o;
  logic [LW-1:0] awlen_i, arlen_i;
  logic [2:0] awsize_i, awprot_i, arsize_i, arprot_i;
  logic [1:0] awburst_i, awlock_i, arburst_i, arlock_i, bresp_o, rresp_o;
  logic [3:0] awcache_i, arcache_i;
  logic awvalid_i, awready_o, wlast_i, wvalid_i, wready_o, bvalid_o, bready_i;
  logic arvalid_i, arready_o, rlast_o, rvalid_o, rready_i;
  logic [DW-1:0] wdata_i, rdata_o, sys_wdata_o, sys_rdata_i;
  logic [DW/8-1:0] wstrb_i, sys_sel_o;
  logic sys_wen_o, sys_ren_o, sys_err_i, sys_ack_i;

  axi_sys_slave #(.AW(AW), .DW(DW), .IW(IW), .LW(LW), .TO(TO)) dut (
    .aclk_i(aclk_i), .arst_i(arst_i),
    .awid_i(awid_i), .awaddr_i(awaddr_i), .awlen_i(awlen_i), .awsize_i(awsize_i),
    .awburst_i(awburst_i), .awprot_i(awprot_i), .awcache_i(awcache_i), .awlock_i(awlock_i),
    .awvalid_i(awvalid_i), .awready_o(awready_o),
    .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wlast_i(wlast_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
    .bid_o(bid_o), .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i),
    .arid_i(arid_i), .araddr_i(araddr_i), .arlen_i(arlen_i), .arsize_i(arsize_i),
    .arburst_i(arburst_i), .arprot_i(arprot_i), .arcache_i(arcache_i), .arlock_i(arlock_i),
    .arvalid_i(arvalid_i), .arready_o(arready_o),
    .rid_o(rid_o), .rdata_o(rdata_o), .rresp_o(rresp_o), .rlast_o(rlast_o), .rvalid_o(rvalid_o),
    .rready_i(rready_i),
    .sys_addr_o(sys_addr_o), .sys_wdata_o(sys_wdata_o), .sys_sel_o(sys_sel_o),
    .sys_wen_o(sys_wen_o), .sys_ren_o(sys_ren_o),
    .sys_rdata_i(sys_rdata_i), .sys_err_i(sys_err_i), .sys_ack_i(sys_ack_i)
  );

  always #5 aclk_i = ~aclk_i;

  typedef struct { logic [IW-1:0] id; logic [AW-1:0] addr; logic [LW-1:0] len; } ax_t;
  typedef struct { logic [DW-1:0] data; logic [DW/8-1:0] strb; logic last; } w_t;
  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; logic [DW/8-1:0] sel; int delay; logic err; } plan_t;
  typedef struct { logic [IW-1:0] id; logic [DW-1:0] data; logic [1:0] resp; logic last; } rsp_t;

  ax_t aw_q[$], ar_q[$];
  w_t w_q[$];
  plan_t wplan_q[$], rplan_q[$];
  rsp_t b_exp_q[$], r_exp_q[$];
  int hs_order[$];

  int checks = 0, failures = 0;
  int exp_wen = 0, exp_ren = 0, wen_cnt = 0, ren_cnt = 0;
  int cyc = 0, cd = -1, strobe_cyc = 0, exp_lat = 0;
  logic lat_pend = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- AXI master channel drivers ----------------
  initial begin : aw_drv
    ax_t a;
    int n;
    awvalid_i = 1'b0; awid_i = '0; awaddr_i = '0; awlen_i = '0;
    awsize_i = '0; awburst_i = '0; awprot_i = '0; awcache_i = '0; awlock_i = '0;
    forever begin
      if (aw_q.size() == 0) begin
        awvalid_i = 1'b0;
        @(posedge aclk_i); #1;
      end else begin
        a = aw_q.pop_front();
        awvalid_i = 1'b1; awid_i = a.id; awaddr_i = a.addr; awlen_i = a.len;
        awsize_i = 3'($urandom); awburst_i = 2'($urandom); awprot_i = 3'($urandom);
        awcache_i = 4'($urandom); awlock_i = 2'($urandom);
        n = 0;
        do begin @(negedge aclk_i); n++; end while (!awready_o && n < 2000);
        if (awready_o) hs_order.push_back(1);
        else chk("aw_handshake_wait", n, 0);
        @(posedge aclk_i); #1;
      end
    end
  end

  initial begin : w_drv
    w_t w;
    int n;
    wvalid_i = 1'b0; wdata_i = '0; wstrb_i = '0; wlast_i = 1'b0;
    forever begin
      if (w_q.size() == 0) begin
        wvalid_i = 1'b0;
        @(posedge aclk_i); #1;
      end else begin
        w = w_q.pop_front();
        wvalid_i = 1'b1; wdata_i = w.data; wstrb_i = w.strb; wlast_i = w.last;
        n = 0;
        do begin @(negedge aclk_i); n++; end while (!wready_o && n < 2000);
        if (!wready_o) chk("w_handshake_wait", n, 0);
        @(posedge aclk_i); #1;
      end
    end
  end

  initial begin : ar_drv
    ax_t a;
    int n;
    arvalid_i = 1'b0; arid_i = '0; araddr_i = '0; arlen_i = '0;
    arsize_i = '0; arburst_i = '0; arprot_i = '0; arcache_i = '0; arlock_i = '0;
    forever begin
      if (ar_q.size() == 0) begin
        arvalid_i = 1'b0;
        @(posedge aclk_i); #1;
      end else begin
        a = ar_q.pop_front();
        arvalid_i = 1'b1; arid_i = a.id; araddr_i = a.addr; arlen_i = a.len;
        arsize_i = 3'($urandom); arburst_i = 2'($urandom); arprot_i = 3'($urandom);
        arcache_i = 4'($urandom); arlock_i = 2'($urandom);
        n = 0;
        do begin @(negedge aclk_i); n++; end while (!arready_o && n < 2000);
        if (arready_o) hs_order.push_back(0);
        else chk("ar_handshake_wait", n, 0);
        @(posedge aclk_i); #1;
      end
    end
  end

  // ------------- system-bus slave model and response monitor -------------
  initial begin : mon
    plan_t p;
    rsp_t e;
    logic prev_wen, pb_v, pb_r, pr_v, pr_r, pr_last;
    logic [IW-1:0] pb_id, pr_id;
    logic [1:0] pb_resp, pr_resp;
    logic [DW-1:0] pr_data, ack_data;
    logic ack_err;
    prev_wen = 1'b0; pb_v = 1'b0; pb_r = 1'b0; pr_v = 1'b0; pr_r = 1'b0; pr_last = 1'b0;
    pb_id = '0; pr_id = '0; pb_resp = '0; pr_resp = '0; pr_data = '0; ack_data = '0; ack_err = 1'b0;
    sys_ack_i = 1'b0; sys_err_i = 1'b0; sys_rdata_i = '0; bready_i = 1'b0; rready_i = 1'b0;
    forever begin
      @(negedge aclk_i);
      cyc++;
      sys_ack_i = 1'b0; sys_err_i = 1'b0; sys_rdata_i = DW'($urandom);
      if (sys_wen_o) begin
        wen_cnt++;
        chk("wen_single_pulse", prev_wen, 1'b0);
        chk("wplan_avail", wplan_q.size() != 0, 1'b1);
        if (wplan_q.size() != 0) begin
          p = wplan_q.pop_front();
          chk("sys_addr_wr", sys_addr_o, p.addr);
          chk("sys_wdata", sys_wdata_o, p.data);
          chk("sys_sel", sys_sel_o, p.sel);
          cd = p.delay; ack_data = p.data; ack_err = p.err;
          strobe_cyc = cyc; lat_pend = 1'b1;
          exp_lat = (p.delay < 0 || p.delay > TO) ? TO + 1 : p.delay + 1;
        end
      end else if (sys_ren_o) begin
        ren_cnt++;
        chk("rplan_avail", rplan_q.size() != 0, 1'b1);
        if (rplan_q.size() != 0) begin
          p = rplan_q.pop_front();
          chk("sys_addr_rd", sys_addr_o, p.addr);
          cd = p.delay; ack_data = p.data; ack_err = p.err;
          strobe_cyc = cyc; lat_pend = 1'b1;
          exp_lat = (p.delay < 0 || p.delay > TO) ? TO + 1 : p.delay + 1;
        end
      end
      prev_wen = sys_wen_o;
      if (cd == 0) begin
        sys_ack_i = 1'b1; sys_err_i = ack_err; sys_rdata_i = ack_data; cd = -1;
      end else if (cd > 0) begin
        cd--;
      end

      bready_i = ($urandom_range(3) != 0);
      rready_i = ($urandom_range(3) != 0);

      if (bvalid_o && !pb_v && lat_pend) begin
        chk("b_latency", cyc - strobe_cyc, exp_lat);
        lat_pend = 1'b0;
      end
      if (pb_v && !pb_r) chk("b_hold", {bvalid_o, bid_o, bresp_o}, {1'b1, pb_id, pb_resp});
      if (bvalid_o && bready_i) begin
        chk("b_expected", b_exp_q.size() != 0, 1'b1);
        if (b_exp_q.size() != 0) begin
          e = b_exp_q.pop_front();
          chk("bid", bid_o, e.id);
          chk("bresp", bresp_o, e.resp);
        end
      end
      pb_v = bvalid_o; pb_r = bready_i; pb_id = bid_o; pb_resp = bresp_o;

      if (rvalid_o && !pr_v && lat_pend) begin
        chk("r_latency", cyc - strobe_cyc, exp_lat);
        lat_pend = 1'b0;
      end
      if (pr_v && !pr_r)
        chk("r_hold", {rvalid_o, rid_o, rresp_o, rlast_o, rdata_o}, {1'b1, pr_id, pr_resp, pr_last, pr_data});
      if (rvalid_o && rready_i) begin
        chk("r_expected", r_exp_q.size() != 0, 1'b1);
        if (r_exp_q.size() != 0) begin
          e = r_exp_q.pop_front();
          chk("rid", rid_o, e.id);
          chk("rdata", rdata_o, e.data);
          chk("rresp", rresp_o, e.resp);
          chk("rlast", rlast_o, e.last);
        end
      end
      pr_v = rvalid_o; pr_r = rready_i; pr_id = rid_o; pr_resp = rresp_o;
      pr_last = rlast_o; pr_data = rdata_o;
    end
  end

  // ---------------- reference model: transaction -> expectations ----------------
  task automatic do_write(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data, input logic [DW/8-1:0] strb,
                          input int len, input int delay, input logic err, input logic last0);
    logic [DW-1:0] d;
    logic [DW/8-1:0] s;
    logic [1:0] r;
    aw_q.push_back('{id, addr, LW'(len)});
    if (len == 0) begin
      w_q.push_back('{data, strb, last0});
      wplan_q.push_back('{addr, data, strb, delay, err});
      exp_wen++;
      r = (delay < 0 || delay > TO || err) ? SLVERR : OKAY;
    end else begin
      for (int i = 0; i <= len; i++) begin
        d = DW'($urandom); s = (DW/8)'($urandom);
        w_q.push_back('{d, s, (i == len)});
      end
      r = SLVERR;
    end
    b_exp_q.push_back('{id, DW'(0), r, 1'b1});
  endtask

  task automatic do_read(input logic [IW-1:0] id, input logic [AW-1:0] addr, input int len,
                         input logic [DW-1:0] data, input int delay, input logic err);
    logic noack;
    ar_q.push_back('{id, addr, LW'(len)});
    if (len == 0) begin
      noack = (delay < 0 || delay > TO);
      rplan_q.push_back('{addr, data, '1, delay, err});
      exp_ren++;
      r_exp_q.push_back('{id, noack ? DW'(0) : data, (noack || err) ? SLVERR : OKAY, 1'b1});
    end else begin
      for (int i = 0; i <= len; i++) r_exp_q.push_back('{id, DW'(0), SLVERR, (i == len)});
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((aw_q.size() + w_q.size() + ar_q.size() + b_exp_q.size() + r_exp_q.size()) != 0 && n < 5000) begin
      @(negedge aclk_i);
      n++;
    end
    chk({"drain_", tag}, b_exp_q.size() + r_exp_q.size() + aw_q.size() + ar_q.size() + w_q.size(), 0);
    repeat (3) @(negedge aclk_i);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, {awready_o, wready_o, arready_o, bvalid_o, rvalid_o, rlast_o, sys_wen_o, sys_ren_o}, 0);
    chk({tag, "_ids"}, {bid_o, bresp_o, rid_o, rresp_o}, 0);
    chk({tag, "_rdata"}, rdata_o, 0);
    chk({tag, "_saddr"}, sys_addr_o, 0);
    chk({tag, "_swdata"}, {sys_sel_o, sys_wdata_o}, 0);
  endtask

  task automatic random_phase(input int count);
    int len, dly;
    for (int i = 0; i < count; i++) begin
      len = ($urandom_range(9) < 2) ? $urandom_range(5, 1) : 0;
      dly = ($urandom_range(7) == 0) ? -1 : $urandom_range(TO);
      if ($urandom_range(1) == 1)
        do_write(IW'($urandom), AW'($urandom), DW'($urandom), (DW/8)'($urandom), len, dly,
                 ($urandom_range(3) == 0), 1'($urandom));
      else
        do_read(IW'($urandom), AW'($urandom), len, DW'($urandom), dly, ($urandom_range(3) == 0));
    end
  endtask

  task automatic reset_midflight();
    int n;
    logic seen_b;
    do_write(4'd6, 32'h4000_0020, 32'hCAFE_F00D, 4'hF, 0, -1, 1'b0, 1'b1);
    n = 0;
    do begin @(negedge aclk_i); n++; end while (!sys_wen_o && n < 200);
    chk("rst_wen_seen", sys_wen_o, 1'b1);
    @(posedge aclk_i); #1 arst_i = 1'b1;
    @(posedge aclk_i); #1 arst_i = 1'b0;
    lat_pend = 1'b0;
    b_exp_q.delete();
    @(negedge aclk_i);
    chk_all_zero("midreset");
    seen_b = 1'b0;
    repeat (2 * TO) begin @(negedge aclk_i); seen_b |= bvalid_o; end
    chk("midreset_no_bvalid", seen_b, 1'b0);
    do_read(4'd9, 32'h4000_0030, 0, 32'hA5A5_5A5A, 3, 1'b0);
    drain("post_reset_read");
  endtask

  initial begin : main
    logic [3:0] ord;
    repeat (2) @(posedge aclk_i);
    #1 arst_i = 1'b0;
    @(negedge aclk_i);
    chk_all_zero("reset");

    // Colliding AW/AR: first grant goes to the write, then alternation.
    hs_order.delete();
    do_write(4'd1, 32'h4000_0000, 32'h1111_1111, 4'hF, 0, 0, 1'b0, 1'b1);
    do_read(4'd2, 32'h4000_0004, 0, 32'h2222_2222, 0, 1'b0);
    do_write(4'd3, 32'h4000_0008, 32'h3333_3333, 4'hF, 0, 1, 1'b0, 1'b1);
    do_read(4'd4, 32'h4000_000C, 0, 32'h4444_4444, 1, 1'b0);
    drain("arb");
    chk("arb_count", hs_order.size(), 4);
    for (int i = 0; i < 4; i++) ord[3-i] = (i < hs_order.size()) && (hs_order[i] == 1);
    chk("arb_order", ord, 4'b1010);

    do_write(4'd3, 32'h4000_0010, 32'hDEAD_BEEF, 4'hF, 0, 2, 1'b0, 1'b1);
    drain("write_basic");
    do_read(4'd5, 32'h4000_0014, 0, 32'h1234_5678, 1, 1'b1);
    drain("read_err");
    do_read(4'd7, 32'h4000_0018, 0, 32'hFFFF_FFFF, -1, 1'b0);
    drain("read_timeout");
    do_write(4'd2, 32'h4000_0100, 32'h0, 4'hF, 3, 0, 1'b0, 1'b1);
    drain("write_burst");
    do_read(4'd4, 32'h4000_0104, 2, 32'h0, 0, 1'b0);
    drain("read_burst");
    do_read(4'd8, 32'h4000_0200, 0, 32'h0BAD_F00D, TO, 1'b0);
    drain("ack_at_expiry");
    do_write(4'd10, 32'h4000_0204, 32'h5566_7788, 4'h5, 0, 0, 1'b0, 1'b0);
    drain("write_nolast_ack0");
    do_write(4'd11, 32'h4000_0208, 32'h99AA_BBCC, 4'hC, 0, -1, 1'b0, 1'b1);
    drain("write_timeout");
    do_write(4'd12, 32'h4000_020C, 32'h0102_0304, 4'h3, 0, TO, 1'b1, 1'b1);
    drain("write_err_at_expiry");

    random_phase(40);
    drain("random");

    reset_midflight();

    chk("wen_count", wen_cnt, exp_wen);
    chk("ren_count", ren_cnt, exp_ren);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog simulation time limit reached (checks=%0d)", checks);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end
endmodule
